blk_scale_buf: RTL and testbench
================================

# blk_scale_buf

Block-exponent scaler that produces the shift amount consumed by the round/saturate narrower. It accepts a fixed-length block of InDw-bit samples and buffers them while tracking the smallest headroom in the block. It then replays the block unchanged, with one shift value that fits the largest-magnitude sample into OutDw bits. It sits directly upstream of `rnd_sat`: `out_data_o` and `out_shift_o` drive its `data_i` and `shift_i`.

## Interface
Parameters:
- InDw, 16, input/output sample width
- OutDw, 8, target width of the downstream narrower (OutDw < InDw)
- ShiftDw, 3, shift amount width
- BlkLen, 4, samples per block; power of two, ≥ 2

Ports:
- clk_i  input  1  clock; all state changes on the rising edge
- rst_ni  input  1  reset; asynchronous and active-low
- tc_mode_i  input  1  0 = unsigned, 1 = signed; sampled at the first accepted sample of a block
- in_valid_i  input  1  input sample valid
- in_ready_o  output  1  block can accept a sample
- in_data_i  input  InDw  input sample
- out_valid_o  output  1  output sample valid
- out_ready_i  input  1  downstream accepts the output sample
- out_data_o  output  InDw  replayed sample; 0 when out_valid_o = 0
- out_shift_o  output  ShiftDw  shift for the current block; constant during the drain
- out_last_o  output  1  marks the last sample of the block

## Operation
- Two states: FILL and DRAIN.
- in_ready_o = (state == FILL).
- out_valid_o = (state == DRAIN).
- FILL:
  - On each in_valid_i && in_ready_o, write in_data_i to buf[wr_cnt] and increment wr_cnt.
  - Update min_h = min(min_h, h(in_data_i)).
  - On the first accept (wr_cnt == 0), latch mode_q = tc_mode_i and seed min_h from that sample.
- Headroom h(x):
  - Unsigned: h = leading-zero count, 0..InDw.
  - Signed: h = number of leading bits equal to the MSB, minus 1, giving 0..InDw-1.
- Shift:
  - sig = InDw − min_h.
  - shift = sig > OutDw ? sig − OutDw : 0, saturated to 2^ShiftDw − 1.
  - A saturated shift is legal; the downstream saturator absorbs the overflow.
- FILL → DRAIN:
  - Triggered by the accept with wr_cnt == BlkLen−1.
  - The shift is computed from min_h including that final sample and registered into out_shift_o on the same edge.
  - wr_cnt wraps to 0.
- DRAIN:
  - out_data_o = buf[rd_cnt].
  - out_last_o = (rd_cnt == BlkLen−1).
  - On out_valid_o && out_ready_i, increment rd_cnt.
  - On the last handshake, go to FILL and wrap rd_cnt to 0.
- out_shift_o holds its value until the next block's transition into DRAIN.
- Single buffer: no input is accepted during DRAIN.
- Reset, including mid-block:
  - state = FILL, wr_cnt = rd_cnt = 0, min_h = InDw, out_shift_o = 0.
  - Any partial block is discarded.
  - Buffer contents are not reset.

## Timing
- Out of reset: in_ready_o = 1; out_valid_o = out_last_o = 0; out_data_o = 0; out_shift_o = 0.
- Latency: out_valid_o rises in the cycle after the BlkLen-th input accept.
- Throughput: at most BlkLen samples per 2·BlkLen cycles.
- Handshake rules:
  - Transfer happens on valid && ready at the rising edge.
  - out_valid_o never deasserts before its handshake.
  - out_data_o, out_shift_o and out_last_o are stable while out_valid_o && !out_ready_i.
- in_valid_i may toggle freely; a gap inside a block simply stalls wr_cnt.
- tc_mode_i changes mid-block are ignored until the next block.
- No simultaneous input/output transfer can occur, because the states are exclusive.

## Structure
- math_pkg gains:
  - function `lead_bits(x, tc)`, returning h for the tc mode;
  - type `blk_state_e` {FILL, DRAIN}.
- One sub-module, `lead_bit_cnt` (InDw parameter): a combinational leading-equal-bit counter.
  - Inputs: x, tc.
  - Output: h, $clog2(InDw+1) bits.
- Counters are $clog2(BlkLen) bits.
- Buffer is a BlkLen×InDw register array.

## Test plan
- Unsigned block {0x0100, 0x0020, 0x0003, 0x00FF}, out_ready_i = 1:
  - min_h = 7, sig = 9, so out_shift_o = 1.
  - Samples replay in order; out_last_o is set on 0x00FF; first out_valid_o is one cycle after the 4th accept.
- Unsigned block containing 0x5FA0:
  - lz = 1, sig = 15, so the shift saturates to 7.
  - The same data as signed gives sig = 16, also saturated to 7.
- Signed block {0xFF80, 0x007F, 0xFFFF, 0x0000}: min_h = 8, sig = 8, so shift = 0.
- All-zero unsigned block: shift = 0.
- Backpressure: hold out_ready_i = 0 for 5 cycles at the 2nd output.
  - Data, shift and last are stable during the stall; in_ready_o = 0 throughout DRAIN.
- Reset mid-block: assert rst_ni = 0 after 2 accepts.
  - Outputs return to reset values and out_shift_o = 0.
  - The next 4 samples {0x0100, 0x0001, 0x0001, 0x0001} form a fresh block with shift 1; the pre-reset samples never appear.
  - tc_mode_i toggled after the first accept does not change the result.

Source files
------------

// File: rtl/math_pkg.sv
// ----------------------------------------------------------------------------
// math_pkg
// Shared helpers for the block-exponent scaler.
//   blk_state_e  : FILL (collecting a block) / DRAIN (replaying it)
//   lead_bits()  : headroom of a sample, unsigned (leading zeros) or
//                  signed (redundant sign bits)
//   block_shift(): shift that fits a block with the given minimum headroom
//                  into the narrower output width, saturated to the shift field
// ----------------------------------------------------------------------------
package math_pkg;

    typedef enum logic {
        FILL  = 1'b0,
        DRAIN = 1'b1
    } blk_state_e;

    // Widest sample lead_bits() can handle; narrower samples are zero-extended.
    localparam int MaxDw = 64;

    // Counts the leading bits that equal the reference bit (0 for unsigned,
    // the MSB for signed). In signed mode the MSB itself always matches, so
    // one is taken off to leave only the redundant sign bits.
    function automatic int lead_bits(input logic [MaxDw-1:0] x,
                                     input int               dw,
                                     input logic             tc);
        logic ref_bit;
        logic run;
        int   cnt;
        ref_bit = tc & x[dw-1];
        run     = 1'b1;
        cnt     = 0;
        for (int i = MaxDw - 1; i >= 0; i--) begin
            if (i < dw) begin
                if (run && (x[i] == ref_bit)) begin
                    cnt = cnt + 1;
                end else begin
                    run = 1'b0;
                end
            end
        end
        if (tc) begin
            cnt = cnt - 1;
        end
        return cnt;
    endfunction

    // Significant bits beyond out_dw become the shift; anything that does
    // not fit the shift field is clamped and left to the downstream saturator.
    function automatic int block_shift(input int min_h,
                                       input int in_dw,
                                       input int out_dw,
                                       input int shift_dw);
        int sig;
        int max_shift;
        int shift;
        sig       = in_dw - min_h;
        max_shift = (1 << shift_dw) - 1;
        shift     = 0;
        if (sig > out_dw) begin
            shift = sig - out_dw;
            if (shift > max_shift) begin
                shift = max_shift;
            end
        end
        return shift;
    endfunction

endpackage

// File: rtl/lead_bit_cnt.sv
// ----------------------------------------------------------------------------
// lead_bit_cnt
// Combinational headroom counter for one sample.
//   x  : sample (InDw bits)
//   tc : 0 = unsigned (count leading zeros, 0..InDw)
//        1 = signed   (count redundant sign bits, 0..InDw-1)
//   h  : headroom, $clog2(InDw+1) bits
// ----------------------------------------------------------------------------
module lead_bit_cnt #(
    parameter int InDw = 16
) (
    input  logic [InDw-1:0]           x,
    input  logic                      tc,
    output logic [$clog2(InDw+1)-1:0] h
);
    import math_pkg::*;

    localparam int HDw = $clog2(InDw + 1);

    always_comb begin
        h = HDw'(lead_bits(MaxDw'(x), InDw, tc));
    end

endmodule

// File: rtl/blk_scale_buf.sv
// ----------------------------------------------------------------------------
// blk_scale_buf
// Block-exponent scaler. Buffers a block of BlkLen samples while tracking the
// smallest headroom, then replays the block unchanged together with one
// shift value that fits the largest-magnitude sample into OutDw bits.
//   clk_i        : clock, rising edge
//   rst_ni       : asynchronous active-low reset
//   tc_mode_i    : 0 unsigned / 1 signed, latched on the first sample of a block
//   in_valid_i   : input sample valid
//   in_ready_o   : high while filling
//   in_data_i    : input sample
//   out_valid_o  : high while draining
//   out_ready_i  : downstream accepts the output sample
//   out_data_o   : replayed sample, 0 when not valid
//   out_shift_o  : shift for the block being drained, held until the next block
//   out_last_o   : last sample of the block
// ----------------------------------------------------------------------------
module blk_scale_buf #(
    parameter int InDw    = 16,
    parameter int OutDw   = 8,
    parameter int ShiftDw = 3,
    parameter int BlkLen  = 4
) (
    input  logic               clk_i,
    input  logic               rst_ni,
    input  logic               tc_mode_i,
    input  logic               in_valid_i,
    output logic               in_ready_o,
    input  logic [InDw-1:0]    in_data_i,
    output logic               out_valid_o,
    input  logic               out_ready_i,
    output logic [InDw-1:0]    out_data_o,
    output logic [ShiftDw-1:0] out_shift_o,
    output logic               out_last_o
);
    import math_pkg::*;

    localparam int              CntW    = $clog2(BlkLen);
    localparam int              HDw     = $clog2(InDw + 1);
    localparam logic [CntW-1:0] LastIdx = CntW'(BlkLen - 1);

    blk_state_e         state_q;
    blk_state_e         state_d;
    logic [CntW-1:0]    wr_cnt_q;
    logic [CntW-1:0]    rd_cnt_q;
    logic [HDw-1:0]     min_h_q;
    logic [HDw-1:0]     min_h_d;
    logic [HDw-1:0]     h_in;
    logic               mode_q;
    logic               tc_eff;
    logic [ShiftDw-1:0] shift_q;
    logic [InDw-1:0]    blk_buf_q [BlkLen];

    logic in_fire;
    logic out_fire;
    logic fill_done;
    logic drain_done;

    assign in_fire    = in_valid_i && in_ready_o;
    assign out_fire   = out_valid_o && out_ready_i;
    assign fill_done  = in_fire && (wr_cnt_q == LastIdx);
    assign drain_done = out_fire && (rd_cnt_q == LastIdx);

    // The first sample of a block uses the live mode input, since mode_q is
    // only loaded on that same edge.
    assign tc_eff = (wr_cnt_q == '0) ? tc_mode_i : mode_q;

    lead_bit_cnt #(
        .InDw(InDw)
    ) u_lead_bit_cnt (
        .x (in_data_i),
        .tc(tc_eff),
        .h (h_in)
    );

    // Running minimum, reseeded by the first sample so a discarded or
    // finished block never leaks into the next one.
    always_comb begin
        min_h_d = min_h_q;
        if (wr_cnt_q == '0) begin
            min_h_d = h_in;
        end else if (h_in < min_h_q) begin
            min_h_d = h_in;
        end
    end

    // State register
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= FILL;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            FILL:    if (fill_done)  state_d = DRAIN;
            DRAIN:   if (drain_done) state_d = FILL;
            default: state_d = FILL;
        endcase
    end

    // Output decode
    always_comb begin
        in_ready_o  = 1'b0;
        out_valid_o = 1'b0;
        out_data_o  = '0;
        out_last_o  = 1'b0;
        case (state_q)
            FILL: begin
                in_ready_o = 1'b1;
            end
            DRAIN: begin
                out_valid_o = 1'b1;
                out_data_o  = blk_buf_q[rd_cnt_q];
                out_last_o  = (rd_cnt_q == LastIdx);
            end
            default: begin
                in_ready_o = 1'b0;
            end
        endcase
    end

    assign out_shift_o = shift_q;

    // Write counter, headroom tracking, mode latch and block shift
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_cnt_q <= '0;
            min_h_q  <= HDw'(InDw);
            mode_q   <= 1'b0;
            shift_q  <= '0;
        end else if (in_fire) begin
            wr_cnt_q <= fill_done ? '0 : wr_cnt_q + 1'b1;
            min_h_q  <= min_h_d;
            if (wr_cnt_q == '0) begin
                mode_q <= tc_mode_i;
            end
            if (fill_done) begin
                shift_q <= ShiftDw'(block_shift(int'(min_h_d), InDw, OutDw, ShiftDw));
            end
        end
    end

    // Read counter
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rd_cnt_q <= '0;
        end else if (out_fire) begin
            rd_cnt_q <= drain_done ? '0 : rd_cnt_q + 1'b1;
        end
    end

    // Sample storage; contents are intentionally left untouched by reset
    always_ff @(posedge clk_i) begin
        if (in_fire) begin
            blk_buf_q[wr_cnt_q] <= in_data_i;
        end
    end

endmodule

// File: tb/tb_blk_scale_buf.sv
// ----------------------------------------------------------------------------
// tb_blk_scale_buf
// Self-checking bench for blk_scale_buf: directed blocks followed by random
// blocks, compared against a reference model of headroom and shift.
// ----------------------------------------------------------------------------
module tb_blk_scale_buf;

    localparam int InDw    = 16;
    localparam int OutDw   = 8;
    localparam int ShiftDw = 3;
    localparam int BlkLen  = 4;

    logic               clk_i;
    logic               rst_ni;
    logic               tc_mode_i;
    logic               in_valid_i;
    logic               in_ready_o;
    logic [InDw-1:0]    in_data_i;
    logic               out_valid_o;
    logic               out_ready_i;
    logic [InDw-1:0]    out_data_o;
    logic [ShiftDw-1:0] out_shift_o;
    logic               out_last_o;

    int checks   = 0;
    int failures = 0;

    logic [InDw-1:0] blk [BlkLen];
    logic            blk_tc;

    blk_scale_buf #(
        .InDw   (InDw),
        .OutDw  (OutDw),
        .ShiftDw(ShiftDw),
        .BlkLen (BlkLen)
    ) dut (
        .clk_i      (clk_i),
        .rst_ni     (rst_ni),
        .tc_mode_i  (tc_mode_i),
        .in_valid_i (in_valid_i),
        .in_ready_o (in_ready_o),
        .in_data_i  (in_data_i),
        .out_valid_o(out_valid_o),
        .out_ready_i(out_ready_i),
        .out_data_o (out_data_o),
        .out_shift_o(out_shift_o),
        .out_last_o (out_last_o)
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Number of bits needed to write a non-negative value
    function automatic int bit_len(input longint v);
        int n;
        n = 0;
        while (v > 0) begin
            n++;
            v = v >>> 1;
        end
        return n;
    endfunction

    // Headroom from magnitude: unsigned uses the value itself, signed folds
    // negatives onto their one's complement so -2^k and 2^k-1 share headroom.
    function automatic int ref_headroom(input logic [InDw-1:0] x, input logic tc);
        int v;
        if (!tc) return InDw - bit_len(longint'(x));
        v = $signed(x);
        if (v < 0) v = -v - 1;
        return InDw - 1 - bit_len(longint'(v));
    endfunction

    function automatic int ref_shift();
        int min_h;
        int sig;
        int s;
        min_h = InDw;
        for (int i = 0; i < BlkLen; i++) begin
            if (ref_headroom(blk[i], blk_tc) < min_h) min_h = ref_headroom(blk[i], blk_tc);
        end
        sig = InDw - min_h;
        s   = (sig > OutDw) ? sig - OutDw : 0;
        if (s > (2 ** ShiftDw) - 1) s = (2 ** ShiftDw) - 1;
        return s;
    endfunction

    // Feed the first n_samples of blk with random valid gaps; tc_mode_i is
    // scrambled (or forced inverted) after the first sample.
    task automatic applyStimulus(input int n_samples, input bit force_toggle);
        bit gap;
        int gaps;
        for (int i = 0; i < n_samples; i++) begin
            gaps = 0;
            do begin
                @(negedge clk_i);
                gap = (gaps < 3) && ($urandom_range(0, 3) == 0);
                if (gap) begin
                    gaps++;
                    in_valid_i = 1'b0;
                    in_data_i  = InDw'($urandom);
                    tc_mode_i  = 1'($urandom_range(0, 1));
                end else begin
                    checkOutput("in_ready_fill", in_ready_o, 1'b1);
                    checkOutput("out_valid_fill", out_valid_o, 1'b0);
                    in_valid_i = 1'b1;
                    in_data_i  = blk[i];
                    if (i == 0)          tc_mode_i = blk_tc;
                    else if (force_toggle) tc_mode_i = ~blk_tc;
                    else                 tc_mode_i = 1'($urandom_range(0, 1));
                end
            end while (gap);
        end
    endtask

    // Drain one block and compare every cycle. stall_idx < 0: random ready;
    // stall_idx = k < BlkLen: 5-cycle stall at sample k; otherwise ready held high.
    task automatic drainAndCheck(input int stall_idx);
        int exp_shift;
        int idx;
        int stall_left;
        int budget;
        exp_shift  = ref_shift();
        idx        = 0;
        stall_left = 5;
        budget     = 0;
        while (idx < BlkLen && budget < 60) begin
            @(negedge clk_i);
            budget++;
            checkOutput("out_valid", out_valid_o, 1'b1);
            checkOutput("out_data", out_data_o, blk[idx]);
            checkOutput("out_last", out_last_o, (idx == BlkLen - 1));
            checkOutput("out_shift", out_shift_o, exp_shift);
            checkOutput("in_ready_drain", in_ready_o, 1'b0);
            in_valid_i = 1'($urandom_range(0, 1));
            in_data_i  = InDw'($urandom);
            if (idx == stall_idx && stall_left > 0) begin
                out_ready_i = 1'b0;
                stall_left--;
            end else if (stall_idx < 0) begin
                out_ready_i = ($urandom_range(0, 2) != 0);
            end else begin
                out_ready_i = 1'b1;
            end
            if (out_ready_i) idx++;
        end
        if (idx < BlkLen) checkOutput("drain_timeout", idx, BlkLen);
        @(negedge clk_i);
        in_valid_i  = 1'b0;
        out_ready_i = 1'b0;
        checkOutput("idle_valid", out_valid_o, 1'b0);
        checkOutput("idle_data", out_data_o, 0);
        checkOutput("idle_last", out_last_o, 1'b0);
        checkOutput("idle_ready", in_ready_o, 1'b1);
        checkOutput("idle_shift_hold", out_shift_o, exp_shift);
    endtask

    task automatic runBlock(input logic [InDw-1:0] a, input logic [InDw-1:0] b,
                            input logic [InDw-1:0] c, input logic [InDw-1:0] d,
                            input logic tc, input int stall_idx);
        blk[0] = a;
        blk[1] = b;
        blk[2] = c;
        blk[3] = d;
        blk_tc = tc;
        applyStimulus(BlkLen, 1'b0);
        drainAndCheck(stall_idx);
    endtask

    function automatic logic [InDw-1:0] rand_sample();
        logic [InDw-1:0] v;
        int              r;
        r = $urandom_range(0, InDw);
        v = InDw'($urandom & ((32'h1 << r) - 1));
        if ($urandom_range(0, 1) == 1) v = ~v;
        return v;
    endfunction

    task automatic checkResetState(input string tag);
        checkOutput({tag, "_in_ready"}, in_ready_o, 1'b1);
        checkOutput({tag, "_out_valid"}, out_valid_o, 1'b0);
        checkOutput({tag, "_out_last"}, out_last_o, 1'b0);
        checkOutput({tag, "_out_data"}, out_data_o, 0);
        checkOutput({tag, "_out_shift"}, out_shift_o, 0);
    endtask

    initial begin
        rst_ni      = 1'b0;
        tc_mode_i   = 1'b0;
        in_valid_i  = 1'b0;
        in_data_i   = '0;
        out_ready_i = 1'b0;
        repeat (2) @(negedge clk_i);
        checkResetState("reset");
        rst_ni = 1'b1;

        $display("[TB] directed blocks");
        runBlock(16'h0100, 16'h0020, 16'h0003, 16'h00FF, 1'b0, 99);
        checkOutput("dir_shift_1", out_shift_o, 1);
        runBlock(16'h0001, 16'h5FA0, 16'h0002, 16'h0003, 1'b0, 99);
        checkOutput("dir_sat_unsigned", out_shift_o, 7);
        runBlock(16'h0001, 16'h5FA0, 16'h0002, 16'h0003, 1'b1, 99);
        checkOutput("dir_sat_signed", out_shift_o, 7);
        runBlock(16'hFF80, 16'h007F, 16'hFFFF, 16'h0000, 1'b1, 99);
        checkOutput("dir_signed_zero", out_shift_o, 0);
        runBlock(16'h5FA0, 16'h0000, 16'h0000, 16'h0000, 1'b0, 99);
        runBlock(16'h0000, 16'h0000, 16'h0000, 16'h0000, 1'b0, 99);
        checkOutput("dir_all_zero", out_shift_o, 0);
        runBlock(16'h1234, 16'h0F0F, 16'h8001, 16'h0042, 1'b0, 1);

        $display("[TB] reset mid-block");
        runBlock(16'h7FFF, 16'h0001, 16'h0001, 16'h0001, 1'b0, 99);
        blk[0] = 16'hAAAA;
        blk[1] = 16'h5555;
        blk_tc = 1'b1;
        applyStimulus(2, 1'b0);
        @(negedge clk_i);
        in_valid_i = 1'b0;
        rst_ni     = 1'b0;
        #1;
        checkResetState("midreset");
        @(negedge clk_i);
        rst_ni = 1'b1;
        blk[0] = 16'h0100;
        blk[1] = 16'h0001;
        blk[2] = 16'h0001;
        blk[3] = 16'h0001;
        blk_tc = 1'b0;
        applyStimulus(BlkLen, 1'b1);
        drainAndCheck(99);
        checkOutput("post_reset_shift", out_shift_o, 1);

        $display("[TB] random blocks");
        for (int n = 0; n < 40; n++) begin
            runBlock(rand_sample(), rand_sample(), rand_sample(), rand_sample(),
                     1'($urandom_range(0, 1)),
                     ($urandom_range(0, 1) == 1) ? -1 : int'($urandom_range(0, BlkLen - 1)));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
